// File: rtl/c432_irq_responder_if.sv
// c432_irq_responder_if: host-side vector handshake between responder and host
interface c432_irq_responder_if;
  logic       irq_valid;
  logic       irq_ready;
  logic [5:0] irq_vec;
  modport master (output irq_valid, output irq_vec, input irq_ready);
  modport slave (input irq_valid, input irq_vec, output irq_ready);
endinterface

// File: rtl/c432_irq_responder.sv
// c432_irq_responder: latches events, drives c432 requests, presents winning vector to host
module c432_irq_responder #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [8:0]                  i_en_mask,
  input  logic [8:0]                  i_evt_a,
  input  logic [8:0]                  i_evt_b,
  input  logic [8:0]                  i_evt_c,
  output logic [8:0]                  o_req_e,
  output logic [8:0]                  o_req_a,
  output logic [8:0]                  o_req_b,
  output logic [8:0]                  o_req_c,
  input  logic                        i_c432_pa,
  input  logic                        i_c432_pb,
  input  logic                        i_c432_pc,
  input  logic [3:0]                  i_c432_chan,
  c432_irq_responder_if.master        irq,
  output logic                        o_err,
  input  logic                        i_err_clr
);
  localparam logic [1:0] S_IDLE = 2'd0, S_SETTLE = 2'd1, S_SAMPLE = 2'd2, S_PRESENT = 2'd3;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [8:0]       r_pend_a, r_pend_b, r_pend_c;
  logic [35:0]      r_prev;
  logic             r_valid;
  logic [5:0]       r_vec;
  logic             r_err;
  logic [35:0]      w_snap;
  logic             w_chg, w_any, w_hit, w_ok, w_samp_err, w_acc;
  logic [1:0]       w_grp;
  logic [8:0]       w_bits, w_bits_sh, w_clr, w_clr_a, w_clr_b, w_clr_c;
  always_comb begin
    w_snap     = {i_en_mask, r_pend_a, r_pend_b, r_pend_c};
    w_chg      = w_snap != r_prev;
    w_any      = |((r_pend_a | r_pend_b | r_pend_c) & i_en_mask);
    w_grp      = i_c432_pa ? 2'd0 : i_c432_pb ? 2'd1 : i_c432_pc ? 2'd2 : 2'd3;
    w_bits     = (w_grp == 2'd0 ? r_pend_a : w_grp == 2'd1 ? r_pend_b :
                  w_grp == 2'd2 ? r_pend_c : 9'd0) & i_en_mask;
    w_bits_sh  = w_bits >> i_c432_chan;
    w_hit      = (i_c432_chan <= 4'd8) && w_bits_sh[0];
    w_ok       = (w_grp != 2'd3) && w_hit;
    w_samp_err = (r_state == S_SAMPLE) && w_any && !w_ok;
    w_acc      = r_valid && irq.irq_ready;
    w_clr      = 9'(w_acc) << r_vec[3:0];
    w_clr_a    = r_vec[5:4] == 2'd0 ? w_clr : 9'd0;
    w_clr_b    = r_vec[5:4] == 2'd1 ? w_clr : 9'd0;
    w_clr_c    = r_vec[5:4] == 2'd2 ? w_clr : 9'd0;
  end
  // Event OR is applied after the clear so a same-cycle re-pulse survives the accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pend_a <= '0;
      r_pend_b <= '0;
      r_pend_c <= '0;
      r_prev   <= '0;
      r_valid  <= 1'b0;
      r_vec    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_pend_a <= (r_pend_a & ~w_clr_a) | i_evt_a;
      r_pend_b <= (r_pend_b & ~w_clr_b) | i_evt_b;
      r_pend_c <= (r_pend_c & ~w_clr_c) | i_evt_c;
      r_prev   <= w_snap;
      if (w_samp_err) r_err <= 1'b1;
      else if (i_err_clr) r_err <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_any) begin
          r_state <= S_SETTLE;
          r_cnt   <= '0;
        end
      end else if (r_state == S_SETTLE) begin
        if (w_chg) r_cnt <= '0;
        else if (r_cnt == CNT_W'(SETTLE_CYC - 1)) r_state <= S_SAMPLE;
        else r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state == S_SAMPLE) begin
        if (w_ok) begin
          r_vec   <= {w_grp, i_c432_chan};
          r_valid <= 1'b1;
          r_state <= S_PRESENT;
        end else r_state <= S_IDLE;
      end else if (w_acc) begin
        r_valid <= 1'b0;
        r_state <= S_IDLE;
      end
    end
  end
  assign o_req_e       = i_en_mask;
  assign o_req_a       = r_pend_a;
  assign o_req_b       = r_pend_b;
  assign o_req_c       = r_pend_c;
  assign irq.irq_valid = r_valid;
  assign irq.irq_vec   = r_vec;
  assign o_err         = r_err;
endmodule

// File: tb/tb_c432_irq_responder.sv
// tb_c432_irq_responder: scoreboard bench with a behavioural c432 and a fault-injection mode
module tb_c432_irq_responder;
  localparam int SC = 2;
  logic clk = 1'b0;
  logic rst_n;
  logic [8:0] en_mask, evt_a, evt_b, evt_c, req_e, req_a, req_b, req_c;
  logic pa, pb, pc, err, err_clr, bad;
  logic [3:0] chan;
  logic g_pa, g_pb;
  logic [8:0] g_sel;
  logic [3:0] g_chan;
  logic [5:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;
  c432_irq_responder_if irq();
  c432_irq_responder #(.SETTLE_CYC(SC), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_en_mask(en_mask), .i_evt_a(evt_a), .i_evt_b(evt_b),
    .i_evt_c(evt_c), .o_req_e(req_e), .o_req_a(req_a), .o_req_b(req_b), .o_req_c(req_c),
    .i_c432_pa(pa), .i_c432_pb(pb), .i_c432_pc(pc), .i_c432_chan(chan), .irq(irq),
    .o_err(err), .i_err_clr(err_clr)
  );
  always #5 clk = ~clk;
  always_comb begin
    g_pa   = |(req_a & req_e);
    g_pb   = |(req_b & req_e);
    g_sel  = g_pa ? (req_a & req_e) : g_pb ? (req_b & req_e) : (req_c & req_e);
    g_chan = 4'hF;
    for (int i = 8; i >= 0; i--) if (g_sel[i]) g_chan = 4'(i);
    pa   = bad ? 1'b1 : g_pa;
    pb   = g_pb;
    pc   = |(req_c & req_e);
    chan = bad ? 4'hC : g_chan;
  end
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (irq.irq_valid) ok = 1'b1;
      else cyc();
    end
  endtask
  task automatic accept(string tag);
    bit ok;
    logic [5:0] e;
    wait_valid(ok);
    chk({tag, "_valid"}, 32'(ok), 1);
    if (!ok) return;
    e = 6'h3F;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk({tag, "_vec"}, 32'(irq.irq_vec), 32'(e));
    irq.irq_ready = 1'b1;
    cyc();
    irq.irq_ready = 1'b0;
    chk({tag, "_drop"}, 32'(irq.irq_valid), 0);
  endtask
  initial begin
    bit ok, saw_valid;
    logic [5:0] e;
    rst_n = 1'b0; en_mask = 9'h1FF; evt_a = 9'h1FF; evt_b = '0; evt_c = '0;
    err_clr = 1'b0; bad = 1'b0; irq.irq_ready = 1'b0;
    cyc(3);
    chk("t1_rst_req_a", 32'(req_a), 0);
    chk("t1_rst_valid", 32'(irq.irq_valid), 0);
    rst_n = 1'b1; evt_a = '0;
    cyc();
    chk("t1_req_a", 32'(req_a), 0);
    chk("t1_valid", 32'(irq.irq_valid), 0);
    chk("t1_err", 32'(err), 0);
    chk("t1_vec", 32'(irq.irq_vec), 0);
    evt_b = 9'h008; exp_q.push_back(6'h13);
    cyc();
    evt_b = '0;
    chk("t2_pend", 32'(req_b), 'h008);
    cyc(SC + 1);
    chk("t2_early", 32'(irq.irq_valid), 0);
    cyc();
    chk("t2_lat", 32'(irq.irq_valid), 1);
    accept("t2");
    chk("t2_clr", 32'(req_b), 0);
    evt_a = 9'h001; evt_c = 9'h020;
    exp_q.push_back(6'h00); exp_q.push_back(6'h25);
    cyc();
    evt_a = '0; evt_c = '0;
    accept("t3a");
    chk("t3_c_left", 32'(req_c), 'h020);
    accept("t3b");
    chk("t3_empty", 32'({req_a, req_b, req_c}), 0);
    evt_a = 9'h001; exp_q.push_back(6'h00);
    cyc();
    evt_a = '0;
    wait_valid(ok);
    chk("t4_valid", 32'(ok), 1);
    for (int i = 0; i < 20; i++) begin
      chk("t4_hold_vec", 32'(irq.irq_vec), 0);
      chk("t4_hold_valid", 32'(irq.irq_valid), 1);
      cyc();
    end
    e = 6'h3F;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk("t4_vec", 32'(irq.irq_vec), 32'(e));
    irq.irq_ready = 1'b1; evt_a = 9'h001;
    cyc();
    irq.irq_ready = 1'b0; evt_a = '0;
    chk("t4_drop", 32'(irq.irq_valid), 0);
    chk("t4_keep", 32'(req_a), 'h001);
    exp_q.push_back(6'h00);
    accept("t4r");
    chk("t4_clr", 32'(req_a), 0);
    bad = 1'b1; evt_a = 9'h010;
    cyc();
    evt_a = '0;
    saw_valid = 1'b0;
    for (int i = 0; i < 30 && !err; i++) begin
      saw_valid |= irq.irq_valid;
      cyc();
    end
    chk("t5_err", 32'(err), 1);
    cyc(10);
    saw_valid |= irq.irq_valid;
    chk("t5_no_valid", 32'(saw_valid), 0);
    chk("t5_pend_kept", 32'(req_a), 'h010);
    bad = 1'b0; exp_q.push_back(6'h04);
    accept("t5");
    chk("t5_sticky", 32'(err), 1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t5_clr", 32'(err), 0);
    evt_b = 9'h004;
    cyc();
    evt_b = '0;
    wait_valid(ok);
    chk("t6_valid", 32'(ok), 1);
    chk("t6_vec", 32'(irq.irq_vec), 'h12);
    rst_n = 1'b0;
    cyc();
    chk("t6_drop", 32'(irq.irq_valid), 0);
    chk("t6_req", 32'({req_a, req_b, req_c}), 0);
    rst_n = 1'b1;
    cyc(8);
    chk("t6_idle", 32'(irq.irq_valid), 0);
    en_mask = 9'h0FF; evt_c = 9'h100;
    cyc();
    evt_c = '0;
    cyc(12);
    chk("t7_masked", 32'(irq.irq_valid), 0);
    chk("t7_pend", 32'(req_c), 'h100);
    en_mask = 9'h1FF; exp_q.push_back(6'h28);
    accept("t7");
    chk("t7_q_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
